// File: rtl/gray_stats_pkg.sv
// Shared types and width helpers for the gray frame statistics block.
package gray_stats_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIV    = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Largest unsigned value of a w-bit pixel.
  function automatic int pix_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int PIX_MAX = pix_max(8);

  // Bits needed to count 0..h*v pixels.
  function automatic int calc_cnt_w(input int h_res, input int v_res);
    return $clog2(h_res * v_res + 1);
  endfunction

  // Sum of h*v pixels of pix_w bits never exceeds this width.
  function automatic int calc_sum_w(input int h_res, input int v_res, input int pix_w);
    return calc_cnt_w(h_res, v_res) + pix_w;
  endfunction

  // Index width for a 0..n-1 counter, at least one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gray_frame_stats_seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, DW cycles per division.
// The quotient register keeps only the low QW bits; callers guarantee the
// true quotient fits.
module seq_divider #(
  parameter int DW = 12,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CW = $clog2(DW + 1);

  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd;
  logic [DW-1:0] rem;
  logic [DW:0]   trial;
  logic          fits;

  // Partial remainder with the next dividend bit shifted in, and the trial compare.
  always_comb begin
    trial = {rem, dvd[DW-1]};
    fits  = (trial >= {1'b0, divisor});
  end

  // Iteration counter and handshake; done is a one-cycle pulse after the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy <= 1'b1;
        cnt  <= CW'(DW);
      end else if (busy) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Datapath: shift dividend out MSB first, restore or subtract, shift quotient in.
  always_ff @(posedge clk) begin
    if (start && !busy) begin
      dvd      <= dividend;
      rem      <= '0;
      quotient <= '0;
    end else if (busy) begin
      dvd      <= {dvd[DW-2:0], 1'b0};
      rem      <= fits ? (trial[DW-1:0] - divisor) : trial[DW-1:0];
      quotient <= {quotient[QW-2:0], fits};
    end
  end

endmodule

// File: rtl/gray_frame_stats.sv
// Per-frame gray statistics: min, max, sum, mean and bright-pixel count,
// reported once per H_RES x V_RES frame through a valid/ready handshake.
module gray_frame_stats
  import gray_stats_pkg::*;
#(
  parameter  int H_RES = 320,
  parameter  int V_RES = 240,
  parameter  int PIX_W = 8,
  localparam int CNT_W = calc_cnt_w(H_RES, V_RES),
  localparam int SUM_W = calc_sum_w(H_RES, V_RES, PIX_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_gray,
  input  logic [PIX_W-1:0] thr,
  output logic             stats_valid,
  input  logic             stats_ready,
  output logic [PIX_W-1:0] st_min,
  output logic [PIX_W-1:0] st_max,
  output logic [SUM_W-1:0] st_sum,
  output logic [PIX_W-1:0] st_mean,
  output logic [CNT_W-1:0] st_bright,
  output logic [15:0]      frame_cnt
);

  localparam int               N        = H_RES * V_RES;
  localparam int               XW       = idx_w(H_RES);
  localparam int               YW       = idx_w(V_RES);
  localparam logic [CNT_W-1:0] N_DIV    = CNT_W'(N);
  localparam logic [PIX_W-1:0] MIN_INIT = PIX_W'(pix_max(PIX_W));
  localparam logic [XW-1:0]    X_LAST   = XW'(H_RES - 1);
  localparam logic [YW-1:0]    Y_LAST   = YW'(V_RES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [PIX_W-1:0] thr_q;
  logic [PIX_W-1:0] acc_min;
  logic [PIX_W-1:0] acc_max;
  logic [SUM_W-1:0] acc_sum;
  logic [CNT_W-1:0] acc_bright;

  logic             beat;
  logic             first_pix;
  logic             last_pix;
  logic             report_xfer;
  logic [PIX_W-1:0] thr_use;
  logic             pix_bright;
  logic [SUM_W-1:0] sum_nxt;
  logic             div_busy;
  logic             div_done;
  logic [PIX_W-1:0] div_quot;

  // Beat qualifiers; the first beat of a frame uses the live threshold it captures.
  always_comb begin
    beat        = pix_valid && pix_ready;
    first_pix   = (x == '0) && (y == '0);
    last_pix    = (x == X_LAST) && (y == Y_LAST);
    report_xfer = stats_valid && stats_ready;
    thr_use     = first_pix ? thr : thr_q;
    pix_bright  = (pix_gray >= thr_use);
    sum_nxt     = acc_sum + SUM_W'(pix_gray);
  end

  // Dividend is the sum including the final beat, so division starts on that beat.
  seq_divider #(
    .DW(SUM_W),
    .QW(PIX_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (beat && last_pix),
    .dividend (sum_nxt),
    .divisor  (SUM_W'(N_DIV)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (beat && last_pix)       state_nxt = DIV;
      DIV:     if (div_done && !div_busy)  state_nxt = REPORT;
      REPORT:  if (stats_ready)            state_nxt = ACCUM;
      default:                             state_nxt = ACCUM;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    pix_ready   = (state == ACCUM);
    stats_valid = (state == REPORT);
  end

  // Raster position and running accumulators; cleared again once a report is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      thr_q      <= '0;
      acc_min    <= MIN_INIT;
      acc_max    <= '0;
      acc_sum    <= '0;
      acc_bright <= '0;
    end else if (beat) begin
      if (first_pix) thr_q <= thr;
      if (pix_gray < acc_min) acc_min <= pix_gray;
      if (pix_gray > acc_max) acc_max <= pix_gray;
      acc_sum    <= sum_nxt;
      acc_bright <= acc_bright + CNT_W'(pix_bright);
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end else if (report_xfer) begin
      x          <= '0;
      y          <= '0;
      acc_min    <= MIN_INIT;
      acc_max    <= '0;
      acc_sum    <= '0;
      acc_bright <= '0;
    end
  end

  // Report registers load as REPORT is entered and hold until the next frame's report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_min    <= '0;
      st_max    <= '0;
      st_sum    <= '0;
      st_mean   <= '0;
      st_bright <= '0;
      frame_cnt <= '0;
    end else begin
      if ((state == DIV) && div_done) begin
        st_min    <= acc_min;
        st_max    <= acc_max;
        st_sum    <= acc_sum;
        st_mean   <= div_quot;
        st_bright <= acc_bright;
      end
      if (report_xfer) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
